// File: rtl/ir_nec_pkg.sv
// Shared types and timing constants for the NEC IR decoder; all windows are in 10 us ticks.
package ir_nec_pkg;

    localparam int unsigned TICK_PERIOD_US = 10;
    localparam int unsigned TICK_RATE_HZ   = 1_000_000 / TICK_PERIOD_US;
    localparam int unsigned DUR_W          = 11;

    typedef logic [DUR_W-1:0] dur_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_L,
        LEAD_H,
        BIT_L,
        BIT_H,
        STOP_L,
        RPT_L
    } state_t;

    localparam dur_t LEAD_MIN  = 11'd800;
    localparam dur_t LEAD_MAX  = 11'd1000;
    localparam dur_t SPACE_MIN = 11'd400;
    localparam dur_t SPACE_MAX = 11'd500;
    localparam dur_t RPT_MIN   = 11'd200;
    localparam dur_t RPT_MAX   = 11'd250;
    localparam dur_t BURST_MIN = 11'd40;
    localparam dur_t BURST_MAX = 11'd70;
    localparam dur_t ONE_MIN   = 11'd150;
    localparam dur_t ONE_MAX   = 11'd200;

    function automatic logic in_win(input dur_t d, input dur_t lo, input dur_t hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/100_000 clocks (10 us time base).
module ir_tick_gen
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned PRESCALE = (CLK_HZ / TICK_RATE_HZ < 1) ? 1 : CLK_HZ / TICK_RATE_HZ;
    localparam int unsigned CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: leader/bit timing, complement check, repeat codes.
// Optional build macro IR_ADDR_CHECK_EN: accept only frames addressed to DEV_ADDR.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter logic [7:0]  DEV_ADDR = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IR_IN,
    output logic [7:0] CMD,
    output logic [7:0] ADDR,
    output logic       CMD_VALID,
    output logic       REPEAT,
    output logic       ERR
);

    logic        tick;
    logic        sync1, sync2, level_q;
    logic        fall, rise;
    dur_t        dur, limit;
    logic        over;
    state_t      state, state_next;
    logic [31:0] sr;
    logic [5:0]  bitcnt;
    logic        have_frame;
    logic        last_bit, frame_ok, addr_ok;
    logic        win_lead, win_space, win_rpt, win_burst, win_one;
    logic        set_valid, set_rpt, set_err, take_bit, bit_val;

    ir_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    // Chain tracks the pin even in reset so a low pin at release is not seen as a falling edge.
    always_ff @(posedge CLK) begin
        sync1   <= IR_IN;
        sync2   <= sync1;
        level_q <= sync2;
    end

    assign fall = level_q & ~sync2;
    assign rise = ~level_q & sync2;

    always_ff @(posedge CLK) begin
        if (RST)
            dur <= '0;
        else if (fall || rise)
            dur <= '0;
        else if (tick && dur != '1)
            dur <= dur + 1'b1;
    end

    assign win_lead  = in_win(dur, LEAD_MIN, LEAD_MAX);
    assign win_space = in_win(dur, SPACE_MIN, SPACE_MAX);
    assign win_rpt   = in_win(dur, RPT_MIN, RPT_MAX);
    assign win_burst = in_win(dur, BURST_MIN, BURST_MAX);
    assign win_one   = in_win(dur, ONE_MIN, ONE_MAX);

    always_comb begin
        limit = '1;
        case (state)
            LEAD_L:                limit = LEAD_MAX;
            LEAD_H:                limit = SPACE_MAX;
            BIT_L, STOP_L, RPT_L:  limit = BURST_MAX;
            BIT_H:                 limit = ONE_MAX;
            default:               limit = '1;
        endcase
    end

    assign over     = (state != IDLE) && (dur > limit);
    assign last_bit = (bitcnt == 6'd31);
    assign frame_ok = (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);

`ifdef IR_ADDR_CHECK_EN
    assign addr_ok = (sr[7:0] == DEV_ADDR);
`else
    logic unused_dev_addr;
    assign unused_dev_addr = ^DEV_ADDR;
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (fall) state_next = LEAD_L;
            LEAD_L:
                if (rise) state_next = win_lead ? LEAD_H : IDLE;
                else if (over) state_next = IDLE;
            LEAD_H:
                if (fall) begin
                    if (win_space)    state_next = BIT_L;
                    else if (win_rpt) state_next = RPT_L;
                    else              state_next = IDLE;
                end else if (over) state_next = IDLE;
            BIT_L:
                if (rise) state_next = win_burst ? BIT_H : IDLE;
                else if (over) state_next = IDLE;
            BIT_H:
                if (fall) begin
                    if (win_burst || win_one) state_next = last_bit ? STOP_L : BIT_L;
                    else                      state_next = IDLE;
                end else if (over) state_next = IDLE;
            STOP_L, RPT_L:
                if (rise || over) state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_comb begin
        set_valid = 1'b0;
        set_rpt   = 1'b0;
        set_err   = 1'b0;
        take_bit  = 1'b0;
        bit_val   = 1'b0;
        case (state)
            LEAD_L:
                set_err = rise ? ~win_lead : over;
            LEAD_H:
                set_err = fall ? ~(win_space | win_rpt) : over;
            BIT_L:
                set_err = rise ? ~win_burst : over;
            BIT_H:
                if (fall) begin
                    take_bit = win_burst | win_one;
                    bit_val  = win_one;
                    set_err  = ~(win_burst | win_one);
                end else begin
                    set_err = over;
                end
            STOP_L:
                if (rise && win_burst) begin
                    set_valid = frame_ok & addr_ok;
                    set_err   = ~frame_ok;
                end else begin
                    set_err = rise | over;
                end
            RPT_L:
                if (rise && win_burst) begin
                    set_rpt = have_frame;
                    set_err = ~have_frame;
                end else begin
                    set_err = rise | over;
                end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr         <= '0;
            bitcnt     <= '0;
            have_frame <= 1'b0;
            CMD        <= '0;
            ADDR       <= '0;
            CMD_VALID  <= 1'b0;
            REPEAT     <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            CMD_VALID <= set_valid;
            REPEAT    <= set_rpt;
            ERR       <= set_err;
            if (state == LEAD_H && state_next == BIT_L)
                bitcnt <= '0;
            if (take_bit) begin
                sr     <= {bit_val, sr[31:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (set_valid) begin
                ADDR       <= sr[7:0];
                CMD        <= sr[23:16];
                have_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder at a 100 kHz clock (one tick per clock); honours IR_ADDR_CHECK_EN.
module tb_ir_nec_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir_in = 1'b1;
    logic [7:0] cmd, addr;
    logic       cmd_valid, rpt, err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_rpt    = 0;
    int n_err    = 0;
    int n_overlap = 0;

    ir_nec_decoder #(.CLK_HZ(100_000), .DEV_ADDR(8'h00)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IR_IN     (ir_in),
        .CMD       (cmd),
        .ADDR      (addr),
        .CMD_VALID (cmd_valid),
        .REPEAT    (rpt),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
        if (rpt)       n_rpt++;
        if (err)       n_err++;
        if (int'(cmd_valid) + int'(rpt) + int'(err) > 1) n_overlap++;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic lvl, input int unsigned n);
        ir_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] word, input int unsigned nbits);
        for (int i = 0; i < int'(nbits); i++) begin
            drive(1'b0, 56);
            drive(1'b1, word[i] ? 169 : 56);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                              input logic [7:0] c, input logic [7:0] nc);
        drive(1'b0, 900);
        drive(1'b1, 450);
        send_bits({nc, c, na, a}, 32);
        drive(1'b0, 56);
        drive(1'b1, 30);
    endtask

    task automatic send_repeat();
        drive(1'b0, 900);
        drive(1'b1, 225);
        drive(1'b0, 56);
        drive(1'b1, 30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        if (cmd !== 8'h00) begin $display("FAIL reset_cmd: got %0h expected 00", cmd); n_fail++; end
        n_checks++;
        if (addr !== 8'h00) begin $display("FAIL reset_addr: got %0h expected 00", addr); n_fail++; end
        n_checks++;
        if (cmd_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b expected 0", cmd_valid); n_fail++; end
        n_checks++;
        if (rpt !== 1'b0) begin $display("FAIL reset_repeat: got %0b expected 0", rpt); n_fail++; end
        n_checks++;
        if (err !== 1'b0) begin $display("FAIL reset_err: got %0b expected 0", err); n_fail++; end
        n_checks++;
        rst = 1'b0;
        drive(1'b1, 20);
    endtask

    task automatic test_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        if (n_valid - v0 != 1) begin $display("FAIL frame_valid_count: got %0d expected 1", n_valid - v0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h45) begin $display("FAIL frame_cmd: got %0h expected 45", cmd); n_fail++; end
        n_checks++;
        if (addr !== 8'h00) begin $display("FAIL frame_addr: got %0h expected 00", addr); n_fail++; end
        n_checks++;
        if (n_err - e0 != 0) begin $display("FAIL frame_err_count: got %0d expected 0", n_err - e0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_repeat();
        int v0, r0, e0;
        v0 = n_valid; r0 = n_rpt; e0 = n_err;
        drive(1'b1, 4000);
        send_repeat();
        if (n_rpt - r0 != 1) begin $display("FAIL repeat_count: got %0d expected 1", n_rpt - r0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h45) begin $display("FAIL repeat_cmd: got %0h expected 45", cmd); n_fail++; end
        n_checks++;
        if (n_err - e0 != 0) begin $display("FAIL repeat_err_count: got %0d expected 0", n_err - e0); n_fail++; end
        n_checks++;
        if (n_valid - v0 != 0) begin $display("FAIL repeat_valid_count: got %0d expected 0", n_valid - v0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_bad_checksum();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBB);
        if (n_err - e0 != 1) begin $display("FAIL cksum_err_count: got %0d expected 1", n_err - e0); n_fail++; end
        n_checks++;
        if (n_valid - v0 != 0) begin $display("FAIL cksum_valid_count: got %0d expected 0", n_valid - v0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h45) begin $display("FAIL cksum_cmd: got %0h expected 45", cmd); n_fail++; end
        n_checks++;
    endtask

    task automatic test_space_timeout();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(1'b0, 900);
        drive(1'b1, 700);
        if (n_err - e0 != 1) begin $display("FAIL timeout_err_count: got %0d expected 1", n_err - e0); n_fail++; end
        n_checks++;
        if (n_valid - v0 != 0) begin $display("FAIL timeout_valid_count: got %0d expected 0", n_valid - v0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_orphan_repeat();
        int r0, e0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 20);
        r0 = n_rpt; e0 = n_err;
        send_repeat();
        if (n_err - e0 != 1) begin $display("FAIL orphan_err_count: got %0d expected 1", n_err - e0); n_fail++; end
        n_checks++;
        if (n_rpt - r0 != 0) begin $display("FAIL orphan_repeat_count: got %0d expected 0", n_rpt - r0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h00) begin $display("FAIL orphan_cmd: got %0h expected 00", cmd); n_fail++; end
        n_checks++;
    endtask

    task automatic test_bad_leader();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(1'b0, 500);
        drive(1'b1, 200);
        if (n_err - e0 != 1) begin $display("FAIL leader_err_count: got %0d expected 1", n_err - e0); n_fail++; end
        n_checks++;
        send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
        if (n_valid - v0 != 1) begin $display("FAIL leader_valid_count: got %0d expected 1", n_valid - v0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h16) begin $display("FAIL leader_cmd: got %0h expected 16", cmd); n_fail++; end
        n_checks++;
        if (n_err - e0 != 1) begin $display("FAIL leader_err_total: got %0d expected 1", n_err - e0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        drive(1'b0, 900);
        drive(1'b1, 450);
        send_bits({8'hF3, 8'h0C, 8'hFF, 8'h00}, 12);
        drive(1'b0, 20);
        rst = 1'b1;
        @(negedge clk);
        if (cmd !== 8'h00) begin $display("FAIL midrst_cmd: got %0h expected 00", cmd); n_fail++; end
        n_checks++;
        if (addr !== 8'h00) begin $display("FAIL midrst_addr: got %0h expected 00", addr); n_fail++; end
        n_checks++;
        if ({cmd_valid, rpt, err} !== 3'b000) begin $display("FAIL midrst_pulses: got %b expected 000", {cmd_valid, rpt, err}); n_fail++; end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 100);
        send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3);
        if (n_valid - v0 != 1) begin $display("FAIL midrst_valid_count: got %0d expected 1", n_valid - v0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h0C) begin $display("FAIL midrst_cmd_after: got %0h expected 0c", cmd); n_fail++; end
        n_checks++;
        if (n_err - e0 != 0) begin $display("FAIL midrst_err_count: got %0d expected 0", n_err - e0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_other_addr();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h10, 8'hEF, 8'h45, 8'hBA);
`ifdef IR_ADDR_CHECK_EN
        if (n_valid - v0 != 0) begin $display("FAIL addr_valid_count: got %0d expected 0", n_valid - v0); n_fail++; end
        n_checks++;
        if (n_err - e0 != 0) begin $display("FAIL addr_err_count: got %0d expected 0", n_err - e0); n_fail++; end
        n_checks++;
        if (cmd !== 8'h0C) begin $display("FAIL addr_cmd: got %0h expected 0c", cmd); n_fail++; end
        n_checks++;
`else
        if (n_valid - v0 != 1) begin $display("FAIL addr_valid_count: got %0d expected 1", n_valid - v0); n_fail++; end
        n_checks++;
        if (n_err - e0 != 0) begin $display("FAIL addr_err_count: got %0d expected 0", n_err - e0); n_fail++; end
        n_checks++;
        if (addr !== 8'h10) begin $display("FAIL addr_value: got %0h expected 10", addr); n_fail++; end
        n_checks++;
        if (cmd !== 8'h45) begin $display("FAIL addr_cmd: got %0h expected 45", cmd); n_fail++; end
        n_checks++;
`endif
    endtask

    task automatic test_exclusive();
        if (n_overlap != 0) begin $display("FAIL pulse_overlap: got %0d cycles expected 0", n_overlap); n_fail++; end
        n_checks++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_repeat();
        test_bad_checksum();
        test_space_timeout();
        test_orphan_repeat();
        test_bad_leader();
        test_reset_mid_frame();
        test_other_addr();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
